// File: rtl/if_prefetch_queue_pkg.sv
// Shared types for the sequential instruction prefetcher.
// Optional macro IF_FETCH_ERR_EN adds a per-entry bus-fault flag.
package if_pkg;

  localparam int IF_ADDR_WIDTH = 32;
  localparam int IF_DATA_WIDTH = 32;
  localparam int INSTR_BYTES   = IF_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [IF_DATA_WIDTH-1:0] instr;
    logic [IF_ADDR_WIDTH-1:0] pc;
`ifdef IF_FETCH_ERR_EN
    logic                     fault;
`endif
  } if_entry_t;

endpackage

// File: rtl/if_prefetch_queue_fifo.sv
// Small FIFO of fetched entries: flush clears pointers, head is read combinationally.
// Storage is reset so the head reads as zero straight after reset.
module if_queue_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [63:0]
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;
  entry_t           ent [DEPTH];

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    entry_t ent_q;
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        ent_q <= '0;
      end else if (do_push && (wr_ptr_q == PTR_W'(gi))) begin
        ent_q <= push_data;
      end
    end
    assign ent[gi] = ent_q;
  end

  assign head = ent[rd_ptr_q];

endmodule

// File: rtl/if_prefetch_queue.sv
// Sequential instruction prefetcher: Wishbone read master feeding a DEPTH-entry queue.
// Optional macro IF_FETCH_ERR_EN adds wb_err_i / out_fault and stops fetching after a bus error.
module if_prefetch_queue
  import if_pkg::*;
#(
  parameter int                    ADDR_WIDTH = IF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = IF_DATA_WIDTH,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(32'h8000_0000)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    redirect_valid,
  input  logic [ADDR_WIDTH-1:0]   redirect_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_instr,
  output logic [ADDR_WIDTH-1:0]   out_pc,
  output logic                    busy,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic                    wb_we_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i
`ifdef IF_FETCH_ERR_EN
  ,
  input  logic                    wb_err_i,
  output logic                    out_fault
`endif
);

  localparam int                    SEL_W = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(SEL_W);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] pc;
`ifdef IF_FETCH_ERR_EN
    logic                  fault;
`endif
  } entry_t;

  fetch_state_t          state_q, state_d;
  logic                  cyc_q, cyc_d;
  logic                  busy_q, busy_d;
  logic                  halt_q, halt_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                  push;
  logic                  bus_err;
  logic                  bus_end;
  entry_t                push_data;
  entry_t                head;
  logic [$clog2(DEPTH):0] q_count;
  logic                  q_full;
  logic                  q_empty;

`ifdef IF_FETCH_ERR_EN
  assign bus_err = wb_err_i;
`else
  assign bus_err = 1'b0;
`endif
  assign bus_end = wb_ack_i || bus_err;

  // A faulting fetch still occupies a slot so decode sees the fault in program order.
  always_comb begin
    push_data       = '0;
    push_data.instr = bus_err ? '0 : wb_dat_i;
    push_data.pc    = adr_q;
`ifdef IF_FETCH_ERR_EN
    push_data.fault = bus_err;
`endif
  end

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    adr_d      = adr_q;
    fetch_pc_d = fetch_pc_q;
    halt_d     = halt_q;
    push       = 1'b0;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      halt_d     = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (!redirect_valid && !q_full && !halt_q) begin
          state_d = FETCH;
          cyc_d   = 1'b1;
          adr_d   = fetch_pc_q;
        end
      end
      FETCH: begin
        if (redirect_valid) begin
          // An in-flight cycle cannot be aborted, so wait it out in DISCARD.
          if (bus_end) begin
            state_d = IDLE;
            cyc_d   = 1'b0;
          end else begin
            state_d = DISCARD;
          end
        end else if (bus_end) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + STEP;
          halt_d     = bus_err;
          cyc_d      = 1'b0;
          state_d    = IDLE;
        end
      end
      DISCARD: begin
        if (bus_end) begin
          state_d = IDLE;
          cyc_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cyc_q      <= 1'b0;
      busy_q     <= 1'b0;
      halt_q     <= 1'b0;
      adr_q      <= '0;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      busy_q     <= busy_d;
      halt_q     <= halt_d;
      adr_q      <= adr_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  if_queue_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (out_ready && !q_empty),
    .head      (head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign out_valid = (q_count != '0);
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
`ifdef IF_FETCH_ERR_EN
  assign out_fault = head.fault;
`endif

  assign busy     = busy_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_adr_o = adr_q;
  assign wb_sel_o = cyc_q ? {SEL_W{1'b1}} : '0;
  assign wb_we_o  = 1'b0;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Randomised bench for if_prefetch_queue: Wishbone slave with variable latency plus a
// queue-level reference model of what decode should see and when the bus should be busy.
module tb_if_prefetch_queue;
  import if_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        busy;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
`ifdef IF_FETCH_ERR_EN
  logic        out_fault;
`endif

  if_prefetch_queue #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH      (DEPTH),
    .RESET_PC   (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .busy           (busy),
    .wb_cyc_o       (wb_cyc_o),
    .wb_stb_o       (wb_stb_o),
    .wb_adr_o       (wb_adr_o),
    .wb_sel_o       (wb_sel_o),
    .wb_we_o        (wb_we_o),
    .wb_dat_i       (wb_dat_i),
    .wb_ack_i       (wb_ack_i)
`ifdef IF_FETCH_ERR_EN
    ,
    .wb_err_i       (wb_err_i),
    .out_fault      (out_fault)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  assign wb_dat_i = wb_cyc_o ? mem_word(wb_adr_o) : 32'hDEAD_BEEF;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state: what decode should see, and where the next fetch goes.
  if_entry_t   exp_q[$];
  logic [31:0] exp_pc = RESET_PC;
  bit          exp_cyc = 0;
  bit          discarding = 0;
  bit          halted = 0;
  bit          last_rst_low = 0;

  // Stimulus knobs and slave state.
  int          p_ready = 100;
  int          min_lat = 0;
  int          max_lat = 0;
  int          redir_mode = 0;
  int          p_redir = 0;
  bit          rst_req = 1;
  bit          late_ack = 0;
  bit          err_mode = 0;
  logic [31:0] err_adr = 32'h8000_0008;
  int          age = 0;
  int          lat = 0;

  task automatic step();
    logic      cyc;
    bit        bus_end;
    bit        pop;
    int        sz;
    if_entry_t ent;
    cyc = wb_cyc_o;

    if (last_rst_low) begin
      check_eq("rst_cyc", cyc, 1'b0);
      check_eq("rst_stb", wb_stb_o, 1'b0);
      check_eq("rst_sel", wb_sel_o, 4'h0);
      check_eq("rst_valid", out_valid, 1'b0);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_adr", wb_adr_o, 32'h0);
      check_eq("rst_out_pc", out_pc, 32'h0);
      check_eq("rst_out_instr", out_instr, 32'h0);
`ifdef IF_FETCH_ERR_EN
      check_eq("rst_fault", out_fault, 1'b0);
`endif
    end else begin
      check_eq("cyc", cyc, exp_cyc);
      check_eq("stb", wb_stb_o, exp_cyc);
      check_eq("busy", busy, exp_cyc);
      check_eq("sel", wb_sel_o, exp_cyc ? 4'hF : 4'h0);
      check_eq("we", wb_we_o, 1'b0);
      if (exp_cyc && !discarding) check_eq("adr", wb_adr_o, exp_pc);
      check_eq("valid", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check_eq("out_pc", out_pc, exp_q[0].pc);
        check_eq("out_instr", out_instr, exp_q[0].instr);
`ifdef IF_FETCH_ERR_EN
        check_eq("out_fault", out_fault, exp_q[0].fault);
`endif
      end
    end

    // Slave: ack (or err) after lat wait cycles; optional stray ack while idle.
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    if (!cyc) begin
      age = 0;
      if (late_ack) begin
        wb_ack_i = 1'b1;
        late_ack = 0;
      end
    end else begin
      if (age == 0) lat = $urandom_range(max_lat, min_lat);
      if (age >= lat) begin
        if (err_mode && wb_adr_o == err_adr) wb_err_i = 1'b1;
        else wb_ack_i = 1'b1;
      end
      age++;
    end

    out_ready = ($urandom_range(0, 99) < p_ready);
    redirect_valid = 1'b0;
    case (redir_mode)
      1: redirect_valid = cyc && (wb_ack_i || wb_err_i) && ($urandom_range(0, 1) == 1);
      2: redirect_valid = cyc && !wb_ack_i && !wb_err_i && (age == 2) && ($urandom_range(0, 1) == 1);
      default: redirect_valid = ($urandom_range(0, 999) < p_redir);
    endcase
    if (redirect_valid) begin
      case ($urandom_range(0, 3))
        0: redirect_pc = 32'h8000_0100;
        1: redirect_pc = 32'hFFFF_FFF8;
        default: redirect_pc = $urandom & 32'hFFFF_FFFC;
      endcase
    end
    reset_n = !rst_req;

    // Model the effect of the coming clock edge.
    last_rst_low = !reset_n;
    if (!reset_n) begin
      exp_q.delete();
      exp_pc = RESET_PC;
      discarding = 0;
      halted = 0;
      exp_cyc = 0;
    end else begin
      sz = exp_q.size();
      bus_end = cyc && (wb_ack_i || wb_err_i);
      if (redirect_valid) begin
        exp_q.delete();
        exp_pc = redirect_pc;
        halted = 0;
        discarding = cyc && !bus_end;
        exp_cyc = cyc && !bus_end;
      end else begin
        pop = (sz != 0) && out_ready;
        if (pop) void'(exp_q.pop_front());
        if (cyc) begin
          if (bus_end && !discarding) begin
            ent = '0;
            ent.pc = exp_pc;
            ent.instr = wb_err_i ? 32'h0 : mem_word(exp_pc);
`ifdef IF_FETCH_ERR_EN
            ent.fault = wb_err_i;
`endif
            exp_q.push_back(ent);
            exp_pc = exp_pc + 32'd4;
            if (wb_err_i) halted = 1;
          end
          if (bus_end) discarding = 0;
          exp_cyc = !bus_end;
        end else begin
          exp_cyc = !halted && (sz < DEPTH);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bit found;
    repeat (2) @(negedge clk);
    last_rst_low = 1;
    rst_req = 1;
    run(3);
    rst_req = 0;

    // Streaming from reset with a zero-wait slave.
    p_ready = 100; min_lat = 0; max_lat = 0; redir_mode = 0; p_redir = 0;
    run(30);
    // Decode stalled: queue fills and the bus must go quiet, then drain.
    p_ready = 0;
    run(40);
    p_ready = 100;
    run(20);
    // Redirects while a slow cycle is waiting.
    min_lat = 3; max_lat = 3; redir_mode = 2; p_ready = 70;
    run(120);
    // Redirects landing on the ack cycle, often together with a pop.
    min_lat = 0; max_lat = 2; redir_mode = 1; p_ready = 50;
    run(200);
    // Mixed random traffic including wraparound redirects.
    redir_mode = 0; p_redir = 30; min_lat = 0; max_lat = 4;
    for (int k = 0; k < 8; k++) begin
      p_ready = $urandom_range(0, 100);
      run(250);
    end

    // Reset during a slow cycle; a stray ack after release must be ignored.
    p_redir = 0; min_lat = 3; max_lat = 3; p_ready = 100;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (wb_cyc_o) found = 1;
      else step();
    end
    check_eq("rst_mid_fetch_wait", found, 1'b1);
    rst_req = 1;
    run(2);
    rst_req = 0;
    late_ack = 1;
    min_lat = 0; max_lat = 1;
    run(40);

`ifdef IF_FETCH_ERR_EN
    // Bus error at 0x8000_0008 halts fetching until a redirect.
    rst_req = 1;
    run(2);
    rst_req = 0;
    err_mode = 1; p_ready = 0; min_lat = 0; max_lat = 1;
    run(30);
    p_ready = 100;
    run(10);
    redir_mode = 0; p_redir = 40;
    run(300);
    err_mode = 0;
`endif

    p_redir = 0;
    run(20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
